// File: rtl/acc_sample_conditioner_if.sv
// Bundle between the I2C driver, the sample conditioner and esti_core.
// The master side owns the I2C results and recal; the slave side produces conditioned samples.
interface acc_sample_conditioner_if;
  logic              end_flag;
  logic [7:0]        received_data [7:0];
  logic              recal;
  logic signed [15:0] acc_out;
  logic              acc_valid;
  logic              calib_done;
  logic signed [15:0] offset_out;

  modport master (
    output end_flag, received_data, recal,
    input  acc_out, acc_valid, calib_done, offset_out
  );

  modport slave (
    input  end_flag, received_data, recal,
    output acc_out, acc_valid, calib_done, offset_out
  );
endinterface

// File: rtl/acc_sample_conditioner.sv
// Accelerometer sample conditioner: edge-detected capture, zero-offset calibration, saturating subtract.
// Optional moving average over 2^AVG_LOG2 samples is enabled by defining ACC_AVG_EN.
module acc_sample_conditioner #(
  parameter int CALIB_LOG2 = 4,
  parameter int AVG_LOG2   = 2
) (
  input  logic clk,
  input  logic reset,
  acc_sample_conditioner_if.slave bus
);
  localparam int SUM_W = 16 + CALIB_LOG2;

  typedef enum logic {CALIB, RUN} state_t;

  state_t                  state_reg, state_next;
  logic                    end_flag_d_reg;
  logic                    ev_reg;
  logic signed [15:0]      raw_reg;
  logic [CALIB_LOG2-1:0]   count_reg;
  logic signed [SUM_W-1:0] sum_reg;
  logic signed [15:0]      offset_reg;
  logic signed [15:0]      acc_out_reg;
  logic                    acc_valid_reg;

  logic                    event_now;
  logic                    last_calib;
  logic                    run_sample;
  logic signed [SUM_W-1:0] sum_plus;
  logic signed [SUM_W-1:0] sum_shift;
  logic signed [16:0]      diff;
  logic signed [15:0]      corr;

  assign event_now  = bus.end_flag & ~end_flag_d_reg;
  assign last_calib = ev_reg && (state_reg == CALIB) && (&count_reg);
  assign run_sample = ev_reg && (state_reg == RUN) && !bus.recal;
  assign sum_plus   = sum_reg + {{CALIB_LOG2{raw_reg[15]}}, raw_reg};
  assign sum_shift  = sum_plus >>> CALIB_LOG2;
  assign diff       = {raw_reg[15], raw_reg} - {offset_reg[15], offset_reg};

  always_comb begin
    corr = diff[15:0];
    if (diff[16] != diff[15]) corr = diff[16] ? 16'sh8000 : 16'sh7FFF;
  end

  // A sample coinciding with recal is dropped before it reaches the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      end_flag_d_reg <= 1'b0;
      ev_reg         <= 1'b0;
      raw_reg        <= '0;
    end else begin
      end_flag_d_reg <= bus.end_flag;
      ev_reg         <= event_now & ~bus.recal;
      if (event_now) raw_reg <= {bus.received_data[0], bus.received_data[1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= CALIB;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.recal)       state_next = CALIB;
    else if (last_calib) state_next = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_reg    <= '0;
      count_reg  <= '0;
      offset_reg <= '0;
    end else if (bus.recal) begin
      sum_reg   <= '0;
      count_reg <= '0;
    end else if (ev_reg && state_reg == CALIB) begin
      if (&count_reg) begin
        offset_reg <= sum_shift[15:0];
        sum_reg    <= '0;
        count_reg  <= '0;
      end else begin
        sum_reg   <= sum_plus;
        count_reg <= count_reg + 1'b1;
      end
    end
  end

`ifdef ACC_AVG_EN
  localparam int AVG_N = 1 << AVG_LOG2;
  localparam int AVG_W = 16 + AVG_LOG2;

  logic signed [15:0]      corr_reg;
  logic                    corr_v_reg;
  logic signed [15:0]      ring_reg [AVG_N];
  logic [AVG_LOG2-1:0]     wr_ptr_reg;
  logic signed [AVG_W-1:0] sum_avg_reg;
  logic signed [AVG_W-1:0] sum_avg_next;
  logic signed [AVG_W-1:0] avg_shift;
  logic                    avg_clear;
  logic                    avg_step;

  assign avg_clear    = last_calib && !bus.recal;
  assign avg_step     = corr_v_reg && !bus.recal;
  assign sum_avg_next = sum_avg_reg + {{AVG_LOG2{corr_reg[15]}}, corr_reg}
                      - {{AVG_LOG2{ring_reg[wr_ptr_reg][15]}}, ring_reg[wr_ptr_reg]};
  assign avg_shift    = sum_avg_next >>> AVG_LOG2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      corr_reg    <= '0;
      corr_v_reg  <= 1'b0;
      wr_ptr_reg  <= '0;
      sum_avg_reg <= '0;
      acc_out_reg <= '0;
      acc_valid_reg <= 1'b0;
      for (int i = 0; i < AVG_N; i++) ring_reg[i] <= '0;
    end else begin
      corr_v_reg    <= run_sample;
      acc_valid_reg <= avg_step;
      if (run_sample) corr_reg <= corr;
      if (avg_clear) begin
        wr_ptr_reg  <= '0;
        sum_avg_reg <= '0;
        for (int i = 0; i < AVG_N; i++) ring_reg[i] <= '0;
      end else if (avg_step) begin
        ring_reg[wr_ptr_reg] <= corr_reg;
        wr_ptr_reg  <= wr_ptr_reg + 1'b1;
        sum_avg_reg <= sum_avg_next;
        acc_out_reg <= avg_shift[15:0];
      end
    end
  end

  logic unused_avg;
  assign unused_avg = ^avg_shift[AVG_W-1:16];
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_out_reg   <= '0;
      acc_valid_reg <= 1'b0;
    end else begin
      acc_valid_reg <= run_sample;
      if (run_sample) acc_out_reg <= corr;
    end
  end
`endif

  assign bus.acc_out    = acc_out_reg;
  assign bus.acc_valid  = acc_valid_reg;
  assign bus.calib_done = (state_reg == RUN);
  assign bus.offset_out = offset_reg;

  logic unused_bits;
  assign unused_bits = ^{bus.received_data[2], bus.received_data[3], bus.received_data[4],
                         bus.received_data[5], bus.received_data[6], bus.received_data[7],
                         sum_shift[SUM_W-1:16]};
endmodule

// File: tb/tb_acc_sample_conditioner.sv
// Randomized bench for acc_sample_conditioner against a queue-based model of the sample rules.
// Honours ACC_AVG_EN the same way the design does.
module tb_acc_sample_conditioner;
  localparam int CL    = 2;
  localparam int AL    = 2;
  localparam int CAL_N = 1 << CL;
  localparam int AVG_N = 1 << AL;
`ifdef ACC_AVG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  acc_sample_conditioner_if bus();

  acc_sample_conditioner #(.CALIB_LOG2(CL), .AVG_LOG2(AL)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // valid monitor: every strobed cycle is logged with its value and cycle number
  longint val_q[$];
  int     tim_q[$];
  always @(posedge clk) begin
    #1;
    if (bus.acc_valid) begin
      val_q.push_back(longint'(bus.acc_out));
      tim_q.push_back(cyc);
    end
  end

  // reference model state
  int     cal_q[$];
  int     win_q[$];
  int     offset_m = 0;
  bit     run_m = 0;

  task automatic check_value(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div(input int s, input int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic model_reset();
    cal_q.delete();
    win_q.delete();
    offset_m = 0;
    run_m = 0;
  endtask

  task automatic check_status(input string tag);
    check_value({tag, "_calib_done"}, longint'(bus.calib_done), longint'(run_m));
    check_value({tag, "_offset"}, longint'(bus.offset_out), longint'(offset_m));
  endtask

  // one I2C transfer: end_flag held for 'hold' cycles, optionally with recal on the first cycle
  task automatic do_sample(input logic [15:0] raw, input int hold, input bit with_recal, input string tag);
    int  r, d, ev_cyc, nv0, exp_valid, exp_val;
    r = int'($signed(raw));
    exp_valid = 0;
    exp_val = 0;
    @(negedge clk);
    for (int i = 2; i < 8; i++) bus.received_data[i] = 8'($urandom);
    bus.received_data[0] = raw[15:8];
    bus.received_data[1] = raw[7:0];
    bus.end_flag = 1'b1;
    bus.recal = with_recal;
    nv0 = val_q.size();
    @(posedge clk);
    #1 ev_cyc = cyc;
    if (with_recal) begin
      cal_q.delete();
      run_m = 0;
    end else if (!run_m) begin
      cal_q.push_back(r);
      if (cal_q.size() == CAL_N) begin
        offset_m = floor_div(qsum(cal_q), CAL_N);
        cal_q.delete();
        win_q.delete();
        for (int i = 0; i < AVG_N; i++) win_q.push_back(0);
        run_m = 1;
      end
    end else begin
      d = r - offset_m;
      if (d > 32767) d = 32767;
      if (d < -32768) d = -32768;
`ifdef ACC_AVG_EN
      win_q.push_back(d);
      void'(win_q.pop_front());
      exp_val = floor_div(qsum(win_q), AVG_N);
`else
      exp_val = d;
`endif
      exp_valid = 1;
    end
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      bus.recal = 1'b0;
    end
    @(negedge clk);
    bus.recal = 1'b0;
    bus.end_flag = 1'b0;
    repeat (3) @(negedge clk);
    check_value({tag, "_nvalid"}, longint'(val_q.size() - nv0), longint'(exp_valid));
    if (val_q.size() > nv0) begin
      check_value({tag, "_acc_out"}, val_q[nv0], longint'(exp_val));
      check_value({tag, "_latency"}, longint'(tim_q[nv0] - ev_cyc), longint'(LAT));
    end
    check_status(tag);
  endtask

  task automatic do_recal(input string tag);
    @(negedge clk);
    bus.recal = 1'b1;
    @(negedge clk);
    bus.recal = 1'b0;
    cal_q.delete();
    run_m = 0;
    check_status(tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_value({tag, "_acc_out"}, longint'(bus.acc_out), 0);
    check_value({tag, "_acc_valid"}, longint'(bus.acc_valid), 0);
    check_value({tag, "_calib_done"}, longint'(bus.calib_done), 0);
    check_value({tag, "_offset"}, longint'(bus.offset_out), 0);
  endtask

  initial begin
    int nv;
    bus.end_flag = 1'b0;
    bus.recal = 1'b0;
    for (int i = 0; i < 8; i++) bus.received_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    model_reset();

    // calibration 0x0100, then a 0x0200 sample
    for (int i = 0; i < 4; i++) do_sample(16'h0100, 1, 0, "cal1");
    check_value("cal1_offset_const", longint'(bus.offset_out), 256);
    do_sample(16'h0200, 2, 0, "sub1");

    // floor rounding of a negative mean
    do_recal("recal_a");
    check_value("recal_a_offset_held", longint'(bus.offset_out), 256);
    do_sample(16'hFFFF, 1, 0, "floor");
    do_sample(16'hFFFF, 1, 0, "floor");
    do_sample(16'hFFFF, 1, 0, "floor");
    do_sample(16'hFFFE, 1, 0, "floor");
    check_value("floor_offset_const", longint'(bus.offset_out), -2);
    do_sample(16'h0000, 1, 0, "floor_run");

    // positive saturation
    do_recal("recal_b");
    for (int i = 0; i < 4; i++) do_sample(16'hFF00, 1, 0, "cal_neg");
    do_sample(16'h7FF0, 1, 0, "sat_pos");
    // negative saturation
    do_recal("recal_c");
    for (int i = 0; i < 4; i++) do_sample(16'h0100, 1, 0, "cal_pos");
    do_sample(16'h8010, 1, 0, "sat_neg");

    // level held high: a single event
    do_sample(16'h1234, 10, 0, "level");

    // zero-offset ramp (averaging ramp when enabled)
    do_recal("recal_d");
    for (int i = 0; i < 4; i++) do_sample(16'h0000, 1, 0, "cal_zero");
    for (int i = 1; i <= 5; i++) do_sample(16'(4 * i), 1, 0, "ramp");

    // recal coincident with an event in RUN
    do_sample(16'h4000, 1, 1, "recal_ev");
    check_value("recal_ev_offset_held", longint'(bus.offset_out), 0);

    // reset after two calibration samples
    do_sample(16'h0300, 1, 0, "pre_rst");
    do_sample(16'h0300, 1, 0, "pre_rst");
    @(negedge clk);
    reset = 1'b1;
    #1 check_zero_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) do_sample(16'h0500, 1, 0, "post_rst");
    check_value("post_rst_not_done", longint'(bus.calib_done), 0);
    do_sample(16'h0500, 1, 0, "post_rst_last");

    // randomized traffic with occasional recal
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 15) == 0) do_recal("rnd_recal");
      do_sample(16'($urandom), $urandom_range(1, 5), ($urandom_range(0, 19) == 0), "rnd");
    end

    // no stray strobes while idle
    nv = val_q.size();
    repeat (10) @(negedge clk);
    check_value("idle_nvalid", longint'(val_q.size() - nv), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/acc_sample_conditioner.md
# acc_sample_conditioner

Conditions raw accelerometer samples between the I2C driver and the position-estimation core. Captures the big-endian 16-bit axis word from the I2C receive buffer on each completed transfer, calibrates a static zero offset over the first samples after reset or on request, subtracts it with saturation, and presents a signed, optionally averaged, sample with a one-cycle valid strobe to `esti_core`.

## Interface
Parameters:
- `CALIB_LOG2`, 4: calibration window is 2^CALIB_LOG2 samples.
- `AVG_LOG2`, 2: moving-average window is 2^AVG_LOG2 samples (used only with `ACC_AVG_EN`).

Ports:
- `clk` in 1: system clock, shared with the I2C driver and `esti_core`.
- `reset` in 1: asynchronous, active-high reset.
- `end_flag` in 1: I2C transfer-complete level; stays high for one or more cycles.
- `received_data` in 8 x 8 (unpacked `[7:0]`): I2C receive bytes; stable while `end_flag` is high.
- `recal` in 1: single-cycle pulse that restarts calibration.
- `acc_out` out 16 signed: conditioned acceleration.
- `acc_valid` out 1: one-cycle strobe; `acc_out` is new.
- `calib_done` out 1: high while in RUN.
- `offset_out` out 16 signed: current offset, for debug.

## Operation
- Edge detect: register `end_flag` into `end_flag_d`. A sample event occurs at a posedge where `end_flag`=1 and `end_flag_d`=0. A held-high level produces exactly one event. Everything runs synchronously on `clk`; nothing is clocked on `end_flag`.
- On an event, capture `raw = {received_data[0], received_data[1]}` as a signed 16-bit value.
- FSM with two states:
  - CALIB (reset state): add each `raw` into `sum`, which is signed, 16+CALIB_LOG2 bits, and count samples. On sample number 2^CALIB_LOG2:
    - `offset <= (sum + raw) >>> CALIB_LOG2` (arithmetic shift, floor).
    - Clear `sum` and the count; go to RUN.
    - No `acc_valid` is issued during CALIB.
  - RUN: compute `diff = raw - offset` at 17 bits signed, then saturate to [-32768, 32767]. That result is `corr`.
- `recal` in any state: clear `sum` and the count, go to CALIB, drop `calib_done`. Keep `offset` until the new calibration completes. If `recal` and an event fall in the same cycle, `recal` wins and the sample is discarded.
- Without `ACC_AVG_EN`, `acc_out <= corr`.
- Reset values of outputs and state:
  - `acc_out`=0, `acc_valid`=0, `calib_done`=0, `offset_out`=0.
  - State CALIB; `sum`, count, `end_flag_d` and the ring buffer all 0.
- Reset asserted mid-calibration or mid-run discards all partial state.

## Timing
- Event at posedge N (raw captured into `raw_q`).
- Without averaging: `acc_out` and `acc_valid`=1 at posedge N+1. Latency is 1 cycle from capture.
- With averaging: `acc_out` and `acc_valid`=1 at posedge N+2.
- `acc_valid` is exactly one cycle wide. Back-to-back events are only possible every 2 cycles, because the edge detect requires `end_flag` to drop first; the pipeline never stalls.
- `calib_done` rises at posedge N+1 of the final calibration sample, together with `offset_out`.
- The first RUN sample can be the very next event.

## Configuration
- `ACC_AVG_EN` defined:
  - Adds a 2^AVG_LOG2-entry ring buffer of `corr` and a running sum of 16+AVG_LOG2 bits signed.
  - Each RUN sample: `sum_avg <= sum_avg + corr - buf[wr_ptr]`; write `corr`; `wr_ptr` increments and wraps from 2^AVG_LOG2-1 to 0.
  - `acc_out = sum_avg_next >>> AVG_LOG2`.
  - Buffer, `sum_avg` and `wr_ptr` clear on reset and on entry to RUN, so the output ramps in from 0.
- `ACC_AVG_EN` undefined: no buffer; `acc_out = corr`, with 1-cycle latency.

## Test plan
- Calibration and subtraction (CALIB_LOG2=2, no averaging): four events with bytes 0x01,0x00 -> `calib_done`=1, `offset_out`=0x0100. Next event 0x02,0x00 -> `acc_out`=0x0100 with a single `acc_valid`.
- Floor rounding: calibration samples -1, -1, -1, -2 -> `offset_out`=-2 (0xFFFE). A following raw of 0 -> `acc_out`=2.
- Saturation: offset -256, raw 0x7FF0 -> `acc_out`=0x7FFF. Offset +256, raw 0x8010 -> `acc_out`=0x8000.
- Level handling: `end_flag` held high for 10 cycles -> exactly one event counted and one `acc_valid`.
- Averaging (`ACC_AVG_EN`, AVG_LOG2=2, offset 0): corr values 4, 8, 12, 16, 20 -> `acc_out` = 1, 3, 6, 10, 14, each at N+2.
- Reset and recal:
  - `reset` pulsed after 2 of 4 calibration samples -> all outputs 0; 4 fresh samples are needed before `calib_done`.
  - `recal` coincident with an event in RUN -> no `acc_valid`, `calib_done`=0, old `offset_out` held until recalibration completes.
